scoreboard_waken: RTL and testbench

- Parametrised, stateful successor to the per-entry wakeup check in the issue stage.
- Holds a per-architectural-register countdown of cycles until the produced value becomes forwardable (Tnew).
- Each cycle it answers ready / delay-exec queries for NUM_WAYS issue slots at the head of the issue queue.
- It is updated by dispatches from the same slots, by pipeline stall and by flush. It replaces per-class write-back comparison with a central scoreboard.

---
 rtl/scoreboard_waken.sv | 228 ++++++++++++++++++++++
 tb/tb_scoreboard_waken.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_waken.sv
// ---------------------------------------------------------------------------
// scoreboard_waken
//
// Central wakeup scoreboard for the issue stage. Each tracked architectural
// register has a countdown of the cycles left until its in-flight producer's
// result can be forwarded (Tnew). Every cycle the block answers ready /
// delay-exec for NUM_WAYS issue slots at the head of the issue queue. The
// ready / delay_exec answers are purely combinational from the registered
// countdowns.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   q_valid            slot i holds a valid instruction to evaluate
//   q_rs1, q_rs2       source register addresses per slot (flattened)
//   q_tuse1, q_tuse2   Tuse per source (flattened)
//   q_allow_delay      slot is an ALU op that may execute in the MEM stage
//   d_valid            slot i dispatches this cycle
//   d_rd, d_tnew       destination register and Tnew of dispatched slots
//   pipe_stall         back end frozen, countdowns hold
//   flush              squash all in-flight producers
//   ready              slot i may issue this cycle
//   delay_exec         slot i may only issue in delay-exec mode
//
// Optional build macro WAKEN_STATS_EN adds two saturating 32-bit counters:
//   stat_stall_cnt     cycles with q_valid[0] && !ready[0]
//   stat_delay_cnt     cycles with ready[0] && delay_exec[0]
// ---------------------------------------------------------------------------
module scoreboard_waken #(
    parameter int NUM_WAYS    = 2,
    parameter int NUM_REGS    = 32,
    parameter int RADDR_W     = $clog2(NUM_REGS),
    parameter int TNEW_W      = 3,
    parameter int DELAY_SLACK = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_WAYS-1:0]         q_valid,
    input  logic [NUM_WAYS*RADDR_W-1:0] q_rs1,
    input  logic [NUM_WAYS*RADDR_W-1:0] q_rs2,
    input  logic [NUM_WAYS*TNEW_W-1:0]  q_tuse1,
    input  logic [NUM_WAYS*TNEW_W-1:0]  q_tuse2,
    input  logic [NUM_WAYS-1:0]         q_allow_delay,
    input  logic [NUM_WAYS-1:0]         d_valid,
    input  logic [NUM_WAYS*RADDR_W-1:0] d_rd,
    input  logic [NUM_WAYS*TNEW_W-1:0]  d_tnew,
    input  logic                        pipe_stall,
    input  logic                        flush,
    output logic [NUM_WAYS-1:0]         ready,
    output logic [NUM_WAYS-1:0]         delay_exec
`ifdef WAKEN_STATS_EN
    ,
    output logic [31:0]                 stat_stall_cnt,
    output logic [31:0]                 stat_delay_cnt
`endif
);

    // Comparisons are done two bits wider than Tnew so tuse + slack + 1
    // never truncates.
    localparam int SUM_W = TNEW_W + 2;

    logic [TNEW_W-1:0]  cnt_q [NUM_REGS];
    logic [TNEW_W-1:0]  cnt_d [NUM_REGS];

    logic [RADDR_W-1:0] q_rs1_w   [NUM_WAYS];
    logic [RADDR_W-1:0] q_rs2_w   [NUM_WAYS];
    logic [TNEW_W-1:0]  q_tuse1_w [NUM_WAYS];
    logic [TNEW_W-1:0]  q_tuse2_w [NUM_WAYS];
    logic [RADDR_W-1:0] d_rd_w    [NUM_WAYS];
    logic [TNEW_W-1:0]  d_tnew_w  [NUM_WAYS];

    logic [NUM_REGS-1:0] hit_w;
    logic [TNEW_W-1:0]   hit_val_w [NUM_REGS];

    logic [NUM_WAYS-1:0] haz1_w;
    logic [NUM_WAYS-1:0] haz2_w;
    logic [NUM_WAYS-1:0] dok1_w;
    logic [NUM_WAYS-1:0] dok2_w;
    logic [NUM_WAYS-1:0] dep_w;

    // ------------------------------------------------------------------
    // Unpack flattened slot fields
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_WAYS; i++) begin
            q_rs1_w[i]   = q_rs1[i*RADDR_W +: RADDR_W];
            q_rs2_w[i]   = q_rs2[i*RADDR_W +: RADDR_W];
            q_tuse1_w[i] = q_tuse1[i*TNEW_W +: TNEW_W];
            q_tuse2_w[i] = q_tuse2[i*TNEW_W +: TNEW_W];
            d_rd_w[i]    = d_rd[i*RADDR_W +: RADDR_W];
            d_tnew_w[i]  = d_tnew[i*TNEW_W +: TNEW_W];
        end
    end

    // ------------------------------------------------------------------
    // Dispatch hit per register. Ways are scanned oldest to youngest so
    // the youngest writer of a register overrides older ones.
    // ------------------------------------------------------------------
    always_comb begin
        hit_w = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            hit_val_w[r] = '0;
            for (int j = 0; j < NUM_WAYS; j++) begin
                if (r != 0 && d_valid[j] && d_rd_w[j] == RADDR_W'(r)) begin
                    hit_w[r]     = 1'b1;
                    hit_val_w[r] = d_tnew_w[j];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Countdown next state: flush > dispatch > decrement > hold
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (flush) begin
                cnt_d[r] = '0;
            end else if (hit_w[r]) begin
                cnt_d[r] = hit_val_w[r];
            end else if (!pipe_stall && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - TNEW_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-source hazard and delay-exec feasibility
    // haz : producer not forwardable in time for normal issue
    // dok : producer forwardable in time if execution slips to MEM
    // ------------------------------------------------------------------
    always_comb begin
        haz1_w = '0;
        haz2_w = '0;
        dok1_w = '0;
        dok2_w = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            haz1_w[i] = (q_rs1_w[i] != '0) &&
                        ({2'b00, cnt_q[q_rs1_w[i]]} > ({2'b00, q_tuse1_w[i]} + SUM_W'(1)));
            haz2_w[i] = (q_rs2_w[i] != '0) &&
                        ({2'b00, cnt_q[q_rs2_w[i]]} > ({2'b00, q_tuse2_w[i]} + SUM_W'(1)));
            dok1_w[i] = (q_rs1_w[i] == '0) ||
                        ({2'b00, cnt_q[q_rs1_w[i]]} <=
                         ({2'b00, q_tuse1_w[i]} + SUM_W'(DELAY_SLACK + 1)));
            dok2_w[i] = (q_rs2_w[i] == '0) ||
                        ({2'b00, cnt_q[q_rs2_w[i]]} <=
                         ({2'b00, q_tuse2_w[i]} + SUM_W'(DELAY_SLACK + 1)));
        end
    end

    // ------------------------------------------------------------------
    // Intra-group dependency: an older way dispatching this cycle writes a
    // register this slot reads; the scoreboard cannot see it until next
    // cycle, so the younger slot is held back.
    // ------------------------------------------------------------------
    always_comb begin
        dep_w = '0;
        for (int i = 1; i < NUM_WAYS; i++) begin
            for (int j = 0; j < i; j++) begin
                if (d_valid[j] && d_rd_w[j] != '0 &&
                    (d_rd_w[j] == q_rs1_w[i] || d_rd_w[j] == q_rs2_w[i])) begin
                    dep_w[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        delay_exec = '0;
        ready      = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            delay_exec[i] = q_valid[i] && q_allow_delay[i] &&
                            (haz1_w[i] || haz2_w[i]) && dok1_w[i] && dok2_w[i];
            ready[i]      = q_valid[i] &&
                            ((!haz1_w[i] && !haz2_w[i]) || delay_exec[i]) &&
                            !dep_w[i];
        end
    end

`ifdef WAKEN_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics for slot 0; only reset clears them.
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] delay_cnt_q;
    logic [31:0] delay_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        delay_cnt_d = delay_cnt_q;
        if (q_valid[0] && !ready[0] && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (ready[0] && delay_exec[0] && delay_cnt_q != '1) begin
            delay_cnt_d = delay_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
            delay_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            delay_cnt_q <= delay_cnt_d;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_delay_cnt = delay_cnt_q;
`endif

endmodule

// File: tb/tb_scoreboard_waken.sv
module tb_scoreboard_waken;

    localparam int NW    = 2;
    localparam int NR    = 32;
    localparam int AW    = 5;
    localparam int TW    = 3;
    localparam int SLACK = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic [NW-1:0]    q_valid;
    logic [NW*AW-1:0] q_rs1;
    logic [NW*AW-1:0] q_rs2;
    logic [NW*TW-1:0] q_tuse1;
    logic [NW*TW-1:0] q_tuse2;
    logic [NW-1:0]    q_allow_delay;
    logic [NW-1:0]    d_valid;
    logic [NW*AW-1:0] d_rd;
    logic [NW*TW-1:0] d_tnew;
    logic             pipe_stall;
    logic             flush;
    logic [NW-1:0]    ready;
    logic [NW-1:0]    delay_exec;
`ifdef WAKEN_STATS_EN
    logic [31:0]      stat_stall_cnt;
    logic [31:0]      stat_delay_cnt;
`endif

    scoreboard_waken #(
        .NUM_WAYS   (NW),
        .NUM_REGS   (NR),
        .RADDR_W    (AW),
        .TNEW_W     (TW),
        .DELAY_SLACK(SLACK)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .q_valid      (q_valid),
        .q_rs1        (q_rs1),
        .q_rs2        (q_rs2),
        .q_tuse1      (q_tuse1),
        .q_tuse2      (q_tuse2),
        .q_allow_delay(q_allow_delay),
        .d_valid      (d_valid),
        .d_rd         (d_rd),
        .d_tnew       (d_tnew),
        .pipe_stall   (pipe_stall),
        .flush        (flush),
        .ready        (ready),
        .delay_exec   (delay_exec)
`ifdef WAKEN_STATS_EN
        ,
        .stat_stall_cnt(stat_stall_cnt),
        .stat_delay_cnt(stat_delay_cnt)
`endif
    );

    always #5 clk = ~clk;

    // stimulus fields
    logic [NW-1:0] qv, ad, dv;
    logic [AW-1:0] rs1_a [NW];
    logic [AW-1:0] rs2_a [NW];
    logic [TW-1:0] tu1_a [NW];
    logic [TW-1:0] tu2_a [NW];
    logic [AW-1:0] drd_a [NW];
    logic [TW-1:0] dtn_a [NW];
    logic          stall, fl;

    // reference model: cycles remaining until each register is forwardable
    int mcnt [NR];
    int exp_stall_n, exp_delay_n;

    int n_chk, n_fail;
    logic [NW-1:0] last_ready, last_delay;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        qv = '0; ad = '0; dv = '0; stall = 1'b0; fl = 1'b0;
        for (int i = 0; i < NW; i++) begin
            rs1_a[i] = '0; rs2_a[i] = '0; tu1_a[i] = '0; tu2_a[i] = '0;
            drd_a[i] = '0; dtn_a[i] = '0;
        end
    endtask

    task automatic apply();
        q_valid       = qv;
        q_allow_delay = ad;
        d_valid       = dv;
        pipe_stall    = stall;
        flush         = fl;
        for (int i = 0; i < NW; i++) begin
            q_rs1[i*AW +: AW]   = rs1_a[i];
            q_rs2[i*AW +: AW]   = rs2_a[i];
            q_tuse1[i*TW +: TW] = tu1_a[i];
            q_tuse2[i*TW +: TW] = tu2_a[i];
            d_rd[i*AW +: AW]    = drd_a[i];
            d_tnew[i*TW +: TW]  = dtn_a[i];
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) mcnt[r] = 0;
        exp_stall_n = 0;
        exp_delay_n = 0;
    endtask

    // Slack needed by a source: how many cycles it still waits vs. its use.
    function automatic void model_outputs(output logic [NW-1:0] er, output logic [NW-1:0] ed);
        er = '0;
        ed = '0;
        for (int i = 0; i < NW; i++) begin
            int  c1, c2;
            bit  h1, h2, ok1, ok2, dep;
            c1  = (rs1_a[i] == 0) ? 0 : mcnt[rs1_a[i]];
            c2  = (rs2_a[i] == 0) ? 0 : mcnt[rs2_a[i]];
            h1  = c1 > int'(tu1_a[i]) + 1;
            h2  = c2 > int'(tu2_a[i]) + 1;
            ok1 = c1 <= int'(tu1_a[i]) + SLACK + 1;
            ok2 = c2 <= int'(tu2_a[i]) + SLACK + 1;
            dep = 1'b0;
            for (int j = 0; j < i; j++)
                if (dv[j] && drd_a[j] != 0 && (drd_a[j] == rs1_a[i] || drd_a[j] == rs2_a[i]))
                    dep = 1'b1;
            ed[i] = qv[i] && ad[i] && (h1 || h2) && ok1 && ok2;
            er[i] = qv[i] && ((!h1 && !h2) || ed[i]) && !dep;
        end
    endfunction

    task automatic model_clock();
        for (int r = 1; r < NR; r++) begin
            int  nv;
            bit  written;
            written = 1'b0;
            nv      = mcnt[r];
            for (int j = 0; j < NW; j++)
                if (dv[j] && drd_a[j] == r) begin
                    written = 1'b1;
                    nv      = dtn_a[j];   // later (younger) way overwrites
                end
            if (fl)
                mcnt[r] = 0;
            else if (written)
                mcnt[r] = nv;
            else if (!stall && mcnt[r] > 0)
                mcnt[r] = mcnt[r] - 1;
        end
    endtask

    task automatic cycle(input string tag);
        logic [NW-1:0] er, ed;
        apply();
        #2;
        model_outputs(er, ed);
        last_ready = ready;
        last_delay = delay_exec;
        chk({tag, "_ready"}, 32'(ready), 32'(er));
        chk({tag, "_delay"}, 32'(delay_exec), 32'(ed));
        if (qv[0] && !er[0]) exp_stall_n++;
        if (er[0] && ed[0])  exp_delay_n++;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        resetn = 1'b0;
        idle();
        apply();
        #12;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_delay", 32'(delay_exec), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // plain query against empty scoreboard
        idle(); qv = 2'b01; rs1_a[0] = 5;
        cycle("p1");
        chk("p1_ready_c", 32'(last_ready), 32'd1);
        chk("p1_delay_c", 32'(last_delay), 32'd0);

        // dispatch rd=5 tnew=3, then watch it count down
        idle(); dv = 2'b01; drd_a[0] = 5; dtn_a[0] = 3;
        cycle("p2_disp");
        idle(); qv = 2'b01; rs1_a[0] = 5;
        cycle("p2_cnt3");
        chk("p2_cnt3_c", 32'(last_ready[0]), 32'd0);
        cycle("p2_cnt2");
        cycle("p2_cnt1");
        chk("p2_cnt1_c", 32'(last_ready[0]), 32'd1);

        // delay-exec window with cnt[7]=3
        idle(); dv = 2'b01; drd_a[0] = 7; dtn_a[0] = 3;
        cycle("p3_disp");
        idle(); qv = 2'b01; rs1_a[0] = 7; ad = 2'b01; stall = 1'b1;
        cycle("p3_dly");
        chk("p3_dly_c", 32'(last_delay[0]), 32'd1);
        chk("p3_rdy_c", 32'(last_ready[0]), 32'd1);
        ad = 2'b00;
        cycle("p3_nodly");
        chk("p3_nodly_c", 32'(last_ready[0]), 32'd0);

        // same-cycle intra-group dependency
        idle(); dv = 2'b01; drd_a[0] = 9; dtn_a[0] = 5; qv = 2'b11; rs2_a[1] = 9;
        cycle("p4_dep");
        chk("p4_dep1_c", 32'(last_ready[1]), 32'd0);
        chk("p4_dep0_c", 32'(last_ready[0]), 32'd1);

        // both ways write rd=4: the younger way (tnew 4) wins
        idle(); dv = 2'b11; drd_a[0] = 4; drd_a[1] = 4; dtn_a[0] = 2; dtn_a[1] = 4;
        cycle("p4_ww");
        idle(); qv = 2'b01; rs1_a[0] = 4; tu1_a[0] = 2; stall = 1'b1;
        cycle("p4_ww_q");
        chk("p4_ww_c", 32'(last_ready[0]), 32'd0);
        tu1_a[0] = 3;
        cycle("p4_ww_q3");
        chk("p4_ww3_c", 32'(last_ready[0]), 32'd1);

        // stall holds countdown
        idle(); dv = 2'b01; drd_a[0] = 3; dtn_a[0] = 2;
        cycle("p5_disp");
        idle(); qv = 2'b01; rs1_a[0] = 3; stall = 1'b1;
        for (int k = 0; k < 3; k++) cycle("p5_stall");
        chk("p5_stall_c", 32'(last_ready[0]), 32'd0);
        stall = 1'b0;
        cycle("p5_rel2");
        cycle("p5_rel1");
        chk("p5_rel1_c", 32'(last_ready[0]), 32'd1);
        cycle("p5_rel0");

        // flush beats simultaneous dispatch
        idle(); dv = 2'b01; drd_a[0] = 3; dtn_a[0] = 4;
        cycle("p6_disp");
        idle(); fl = 1'b1; dv = 2'b01; drd_a[0] = 3; dtn_a[0] = 7;
        cycle("p6_flush");
        idle(); qv = 2'b01; rs1_a[0] = 3;
        cycle("p6_after");
        chk("p6_after_c", 32'(last_ready[0]), 32'd1);

        // asynchronous reset mid-countdown
        idle(); dv = 2'b01; drd_a[0] = 6; dtn_a[0] = 7;
        cycle("p7_disp");
        idle(); qv = 2'b01; rs1_a[0] = 6;
        apply();
        #2;
        chk("p7_pre", 32'(ready[0]), 32'd0);
        resetn = 1'b0;
        #1;
        model_reset();
        chk("p7_async", 32'(ready[0]), 32'd1);
`ifdef WAKEN_STATS_EN
        chk("p7_stat_stall", stat_stall_cnt, 32'd0);
        chk("p7_stat_delay", stat_delay_cnt, 32'd0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        idle();
        apply();
        @(posedge clk);
        model_clock();
        #1;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            qv    = NW'($urandom);
            ad    = NW'($urandom);
            dv    = NW'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            fl    = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < NW; i++) begin
                rs1_a[i] = AW'($urandom_range(0, 7));
                rs2_a[i] = AW'($urandom_range(0, 7));
                tu1_a[i] = TW'($urandom_range(0, 7));
                tu2_a[i] = TW'($urandom_range(0, 7));
                drd_a[i] = AW'($urandom_range(0, 7));
                dtn_a[i] = TW'($urandom_range(0, 7));
            end
            cycle("rnd");
        end

`ifdef WAKEN_STATS_EN
        chk("stat_stall", stat_stall_cnt, 32'(exp_stall_n));
        chk("stat_delay", stat_delay_cnt, 32'(exp_delay_n));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
